switch_event_arbiter: RTL

SWITCH_EVENT_ARBITER -- requirements
Module: switch_event_arbiter

---
 rtl/switch_event_arbiter_if.sv | 31 +++
 rtl/switch_event_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/switch_event_arbiter_if.sv
// Switch/event bundle for switch_event_arbiter.
//   i_Switch      : raw push-button levels, channels 0-3
//   o_LED         : per-channel toggle state
//   o_Event_Valid : one-cycle pulse for a granted release event
//   o_Event_Id    : channel of the granted event (valid with o_Event_Valid)
//   o_Pending     : per-channel releases not yet granted
// slave  : the arbiter side (drives the outputs)
// master : the stimulus side (drives the switches)
interface switch_event_arbiter_if;
  logic [3:0] i_Switch;
  logic [3:0] o_LED;
  logic       o_Event_Valid;
  logic [1:0] o_Event_Id;
  logic [3:0] o_Pending;

  modport slave (
    input  i_Switch,
    output o_LED,
    output o_Event_Valid,
    output o_Event_Id,
    output o_Pending
  );

  modport master (
    output i_Switch,
    input  o_LED,
    input  o_Event_Valid,
    input  o_Event_Id,
    input  o_Pending
  );
endinterface

// File: rtl/switch_event_arbiter.sv
// Four-channel push-button front end: synchronize, debounce, detect releases,
// and grant one release event per clock in round-robin order. Each grant
// toggles that channel's LED.
//   i_Clk   : system clock, rising edge
//   i_Reset : asynchronous active-high reset
//   bus     : switch_event_arbiter_if.slave (i_Switch in; o_LED, o_Event_Valid,
//             o_Event_Id, o_Pending out, all registered)
module switch_event_arbiter #(
  parameter int unsigned DEBOUNCE_LIMIT = 250000
) (
  input logic                  i_Clk,
  input logic                  i_Reset,
  switch_event_arbiter_if.slave bus
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_LIMIT);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_LIMIT - 1);

  logic [3:0]      sync1_q, sync2_q;
  logic [3:0]      stable_q, stable_d;
  logic [3:0]      stable_dly_q;
  logic [CntW-1:0] cnt_q [4];
  logic [CntW-1:0] cnt_d [4];
  logic [3:0]      pending_q, pending_d;
  logic [3:0]      led_q, led_d;
  logic            valid_q, valid_d;
  logic [1:0]      id_q, id_d;
  logic [1:0]      ptr_q, ptr_d;

  logic [3:0]      release_det;
  logic            grant_valid;
  logic [1:0]      grant_id;
  logic [1:0]      idx;
  logic [3:0]      grant_oh;

  // Debounce: the counter saturates at CntMax, where the stable level flips.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] != CntMax) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end
    end
  end

  // A stable 1->0 seen one edge ago becomes pending on the next edge.
  assign release_det = stable_dly_q & ~stable_q;

  // Round-robin search starting at the pointer, wrapping 3->0.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = ptr_q;
    idx         = ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!grant_valid && pending_q[idx]) begin
        grant_valid = 1'b1;
        grant_id    = idx;
      end
    end
  end

  always_comb begin
    grant_oh  = grant_valid ? (4'b0001 << grant_id) : 4'b0000;
    // A new release on the grant edge survives the clear.
    pending_d = (pending_q & ~grant_oh) | release_det;
    led_d     = led_q ^ grant_oh;
    valid_d   = grant_valid;
    id_d      = grant_valid ? grant_id : id_q;
    ptr_d     = grant_valid ? grant_id + 2'd1 : ptr_q;
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      pending_q    <= '0;
      led_q        <= '0;
      valid_q      <= 1'b0;
      id_q         <= '0;
      ptr_q        <= '0;
    end else begin
      sync1_q      <= bus.i_Switch;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      pending_q    <= pending_d;
      led_q        <= led_d;
      valid_q      <= valid_d;
      id_q         <= id_d;
      ptr_q        <= ptr_d;
    end
  end

  assign bus.o_LED         = led_q;
  assign bus.o_Event_Valid = valid_q;
  assign bus.o_Event_Id    = id_q;
  assign bus.o_Pending     = pending_q;

endmodule
